bcd_scan_display: RTL and testbench

//  - Sits downstream of the binary-to-BCD converter; takes its huns/tens/ones digits and

---
 rtl/bcd_display_pkg.sv | 35 +++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/bcd_scan_display.sv | 118 +++++++++++
 tb/tb_bcd_scan_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants for the 3-digit scanned 7-segment display: active-low segment
// patterns (bit0=a .. bit6=g), digit count and the scan state type.
package bcd_display_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Slot 0 is the hundreds digit, driven by dig_n bit 2.
  function automatic logic [2:0] digit_enable(input logic [1:0] slot);
    case (slot)
      2'd0:    digit_enable = 3'b011;
      2'd1:    digit_enable = 3'b101;
      2'd2:    digit_enable = 3'b110;
      default: digit_enable = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD code to active-low 7-segment pattern; codes above 9 show a dash.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    case (code)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode 3-digit display driver with a blank gap per slot.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros in huns/tens.
module bcd_scan_display
  import bcd_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] huns,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg_n,
  output logic [2:0] dig_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [3:0]    huns_q, tens_q, ones_q;
  logic [3:0]    code_q;
  logic          blank_q;
  logic [3:0]    sel_code;
  logic          sel_blank;
  logic [6:0]    dec_seg;
  logic          slot_end, on_start;

  assign slot_end = (state == ON) && (cnt == CNT_LAST);
  assign on_start = (state == BLANK) && (cnt == BLANK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      huns_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else if (load) begin
      huns_q <= huns;
      tens_q <= tens;
      ones_q <= ones;
    end
  end

  always_comb begin
    sel_code  = ones_q;
    sel_blank = 1'b0;
    case (slot)
      2'd0:    sel_code = huns_q;
      2'd1:    sel_code = tens_q;
      default: sel_code = ones_q;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2'd0)
      sel_blank = (huns_q == 4'd0);
    else if (slot == 2'd1)
      sel_blank = (huns_q == 4'd0) && (tens_q == 4'd0);
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (cnt == BLANK_LAST) state_next = ON;
      ON:      if (cnt == CNT_LAST) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // The digit is snapshotted only at the start of an ON phase, so a load never
  // disturbs the slot currently lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      cnt     <= '0;
      slot    <= 2'd0;
      code_q  <= '0;
      blank_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (slot_end)
        slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
      if (on_start) begin
        code_q  <= sel_code;
        blank_q <= sel_blank;
      end
    end
  end

  bcd_to_7seg u_dec (
    .code  (code_q),
    .seg_n (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= SEG_OFF;
      dig_n      <= 3'b111;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= slot_end && (slot == 2'd2);
      if (state == ON) begin
        dig_n <= digit_enable(slot);
        seg_n <= blank_q ? SEG_OFF : dec_seg;
      end else begin
        dig_n <= 3'b111;
        seg_n <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized scoreboard bench for bcd_scan_display (SCAN_DIV=8, BLANK_CYCLES=2);
// expectations come from an arithmetic timing model of the scan.
module tb_bcd_scan_display;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 3 * SD;
  localparam logic [6:0] SEG_TBL [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] huns = '0, tens = '0, ones = '0;
  logic [6:0] seg_n;
  logic [2:0] dig_n;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0] m_h = '0, m_t = '0, m_o = '0;
  logic [9:0] exp_q [$];

  bcd_scan_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .huns       (huns),
    .tens       (tens),
    .ones       (ones),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    return (code < 4'd10) ? SEG_TBL[code] : 7'b0111111;
  endfunction

  function automatic logic [9:0] expect_slot(input int s, input logic [3:0] h,
                                             input logic [3:0] t, input logic [3:0] o);
    logic [3:0] code;
    logic [2:0] dig;
    logic       blank;
    code = (s == 0) ? h : (s == 1) ? t : o;
    dig = 3'b111;
    dig[2-s] = 1'b0;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (s == 0 && h == 4'd0) || (s == 1 && h == 4'd0 && t == 4'd0);
`endif
    return {dig, blank ? 7'h7F : seg_of(code)};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for the display (cycle %0d)", name, cyc);
  endtask

  // Reference: after edge j a slot starts lighting when j mod SD == BC, showing the
  // shadow digits as they stood before that edge.
  always @(posedge clk or negedge rst_n) begin
    int c;
    if (!rst_n) begin
      cyc <= 0;
      m_h <= '0;
      m_t <= '0;
      m_o <= '0;
      exp_q.delete();
    end else begin
      c = cyc + 1;
      cyc <= c;
      if (c % SD == BC)
        exp_q.push_back(expect_slot((c / SD) % 3, m_h, m_t, m_o));
      if (load) begin
        m_h <= huns;
        m_t <= tens;
        m_o <= ones;
      end
    end
  end

  logic [2:0] prev_dig = 3'b111;
  logic [9:0] cur_exp = '0;
  int blank_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dig  = 3'b111;
      blank_run = 0;
    end else begin
      checkOutput("frame_tick", 16'(frame_tick), 16'((cyc > 0) && (cyc % FRAME == 0)));
      checkOutput("dig_onehot", 16'($countones(~dig_n) <= 1), 16'd1);
      if (dig_n == 3'b111) begin
        if (cyc > 0) blank_run++;
        checkOutput("blank_seg", 16'(seg_n), 16'h7F);
      end else if (prev_dig == 3'b111) begin
        checkOutput("blank_gap", 16'(blank_run), 16'(BC));
        checkOutput("slot_phase", 16'(cyc % SD), 16'(BC + 1));
        blank_run = 0;
        if (exp_q.size() == 0) begin
          timeoutFail("scoreboard_empty");
        end else begin
          cur_exp = exp_q.pop_front();
          checkOutput("slot_value", {6'd0, dig_n, seg_n}, {6'd0, cur_exp});
        end
      end else begin
        checkOutput("slot_hold", {6'd0, dig_n, seg_n}, {6'd0, cur_exp});
      end
      prev_dig = dig_n;
    end
  end

  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] o, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      load = 1'b1;
      huns = (i == hold - 1) ? h : 4'($urandom_range(0, 15));
      tens = (i == hold - 1) ? t : 4'($urandom_range(0, 15));
      ones = (i == hold - 1) ? o : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitPhase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % FRAME != ph) && n < 4 * FRAME);
    if (cyc % FRAME != ph) timeoutFail("wait_phase");
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rh, rt, ro;
    #23;
    checkOutput("reset_seg", 16'(seg_n), 16'h7F);
    checkOutput("reset_dig", 16'(dig_n), 16'h7);
    checkOutput("reset_tick", 16'(frame_tick), 16'h0);
    releaseReset();

    applyStimulus(4'd1, 4'd2, 4'd3, 1);
    runCycles(2 * FRAME);

    // Load while tens is lit: tens keeps showing 2, the next ones slot shows 6.
    waitPhase(12);
    applyStimulus(4'd4, 4'd5, 4'd6, 1);
    checkOutput("midload_tens_dig", 16'(dig_n), 16'b101);
    checkOutput("midload_tens_seg", 16'(seg_n), 16'b0100100);
    waitPhase(SD * 2 + BC + 1);
    checkOutput("midload_ones_seg", 16'(seg_n), 16'b0000010);

    applyStimulus(4'hC, 4'd0, 4'd0, 1);
    runCycles(3);
    waitPhase(BC + 1);
    checkOutput("invalid_dig", 16'(dig_n), 16'b011);
    checkOutput("invalid_seg", 16'(seg_n), 16'b0111111);

    applyStimulus(4'd0, 4'd0, 4'd7, 1);
    runCycles(3);
    waitPhase(BC + 1);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("lz_huns_seg", 16'(seg_n), 16'h7F);
`else
    checkOutput("lz_huns_seg", 16'(seg_n), 16'b1000000);
`endif
    checkOutput("lz_huns_dig", 16'(dig_n), 16'b011);
    waitPhase(SD + BC + 1);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("lz_tens_seg", 16'(seg_n), 16'h7F);
`else
    checkOutput("lz_tens_seg", 16'(seg_n), 16'b1000000);
`endif
    waitPhase(2 * SD + BC + 1);
    checkOutput("lz_ones_seg", 16'(seg_n), 16'b1111000);

    applyStimulus(4'd0, 4'd0, 4'd0, 1);
    runCycles(3);
    waitPhase(2 * SD + BC + 1);
    checkOutput("zero_ones_seg", 16'(seg_n), 16'b1000000);

    for (int k = 0; k < 40; k++) begin
      rh = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      rt = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ro = 4'($urandom_range(0, 15));
      applyStimulus(rh, rt, ro, $urandom_range(1, 3));
      runCycles($urandom_range(0, 20));
    end

    // Asynchronous reset while a digit is lit must blank the outputs at once.
    begin
      int n;
      n = 0;
      while (dig_n == 3'b111 && n < 2 * SD) begin
        @(negedge clk);
        n++;
      end
      if (dig_n == 3'b111) timeoutFail("wait_lit");
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_seg", 16'(seg_n), 16'h7F);
    checkOutput("midreset_dig", 16'(dig_n), 16'h7);
    checkOutput("midreset_tick", 16'(frame_tick), 16'h0);
    runCycles(3);
    releaseReset();
    runCycles(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
